// File: rtl/stream_sum_accumulator.sv
// rtl/stream_sum_accumulator.sv - accumulates COUNT stream samples into a wide total with sticky overflow
module stream_sum_accumulator #(
    parameter int IN_WIDTH  = 3,
    parameter int ACC_WIDTH = 8,
    parameter int COUNT     = 4,
    localparam int CNT_W    = $clog2(COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_overflow,
    output logic [CNT_W-1:0]     sample_cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]   res_sum_q, res_sum_d;
    logic                   res_ovf_q, res_ovf_d;
    logic [ACC_WIDTH:0]     sum_ext;

    // Carry bit of the widened add is what feeds the sticky overflow flag.
    assign sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, in_data};

    // Handshake flags decode state only, so neither depends on in_valid/out_ready.
    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == HOLD);
    assign out_sum      = res_sum_q;
    assign out_overflow = res_ovf_q;
    assign sample_cnt   = cnt_q;

    // Next-state logic: clear aborts the group/result; otherwise accumulate or wait for the consumer.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        res_sum_d = res_sum_q;
        res_ovf_d = res_ovf_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt_q == LAST_CNT) begin
                            res_sum_d = sum_ext[ACC_WIDTH-1:0];
                            res_ovf_d = ovf_q | sum_ext[ACC_WIDTH];
                            acc_d     = '0;
                            cnt_d     = '0;
                            ovf_d     = 1'b0;
                            state_d   = HOLD;
                        end else begin
                            acc_d = sum_ext[ACC_WIDTH-1:0];
                            ovf_d = ovf_q | sum_ext[ACC_WIDTH];
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // State register; reset also zeroes the presented result, unlike clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            res_sum_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            res_sum_q <= res_sum_d;
            res_ovf_q <= res_ovf_d;
        end
    end

endmodule

// File: tb/tb_stream_sum_accumulator.sv
// tb/tb_stream_sum_accumulator.sv - scoreboard bench for stream_sum_accumulator
module tb_stream_sum_accumulator;

    logic       clk;
    logic       rst;
    logic       clear;

    logic       a_in_valid;
    logic       a_in_ready;
    logic [2:0] a_in_data;
    logic       a_out_valid;
    logic       a_out_ready;
    logic [7:0] a_out_sum;
    logic       a_out_overflow;
    logic [1:0] a_cnt;

    logic       b_in_valid;
    logic       b_in_ready;
    logic [2:0] b_in_data;
    logic       b_out_valid;
    logic       b_out_ready;
    logic [3:0] b_out_sum;
    logic       b_out_overflow;
    logic [1:0] b_cnt;

    int tests_run;
    int tests_failed;

    logic [8:0] a_q[$];
    logic [4:0] b_q[$];
    logic [8:0] a_exp;
    logic [4:0] b_exp;

    stream_sum_accumulator #(.IN_WIDTH(3), .ACC_WIDTH(8), .COUNT(4)) dut_a (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_overflow(a_out_overflow), .sample_cnt(a_cnt)
    );

    stream_sum_accumulator #(.IN_WIDTH(3), .ACC_WIDTH(4), .COUNT(4)) dut_b (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_overflow(b_out_overflow), .sample_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result scoreboards: compare on the negedge before an output handshake edge.
    always @(negedge clk) begin
        if (!rst && !clear && a_out_valid && a_out_ready) begin
            tests_run++;
            if (a_q.size() == 0) begin
                tests_failed++;
                $display("FAIL a_result_unexpected got sum=%0d ovf=%0d, required none", a_out_sum, a_out_overflow);
            end else begin
                a_exp = a_q.pop_front();
                if ({a_out_overflow, a_out_sum} !== a_exp) begin
                    tests_failed++;
                    $display("FAIL a_result got sum=%0d ovf=%0d, required sum=%0d ovf=%0d",
                             a_out_sum, a_out_overflow, a_exp[7:0], a_exp[8]);
                end
            end
        end
        if (!rst && !clear && b_out_valid && b_out_ready) begin
            tests_run++;
            if (b_q.size() == 0) begin
                tests_failed++;
                $display("FAIL b_result_unexpected got sum=%0d ovf=%0d, required none", b_out_sum, b_out_overflow);
            end else begin
                b_exp = b_q.pop_front();
                if ({b_out_overflow, b_out_sum} !== b_exp) begin
                    tests_failed++;
                    $display("FAIL b_result got sum=%0d ovf=%0d, required sum=%0d ovf=%0d",
                             b_out_sum, b_out_overflow, b_exp[3:0], b_exp[4]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [2:0] d);
        a_in_valid = 1'b1;
        a_in_data  = d;
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] d);
        b_in_valid = 1'b1;
        b_in_data  = d;
        tick();
        b_in_valid = 1'b0;
    endtask

    task automatic drain_a();
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
    endtask

    task automatic drain_b();
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests_run++;
        if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b, required 1", a_in_ready); end
        tests_run++;
        if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b, required 0", a_out_valid); end
        tests_run++;
        if (a_out_sum !== 8'd0) begin tests_failed++; $display("FAIL reset_out_sum got %0d, required 0", a_out_sum); end
        tests_run++;
        if (a_out_overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_out_overflow got %b, required 0", a_out_overflow); end
        tests_run++;
        if (a_cnt !== 2'd0) begin tests_failed++; $display("FAIL reset_sample_cnt got %0d, required 0", a_cnt); end
    endtask

    task automatic test_defaults();
        logic [2:0] vals[4];
        vals = '{3'd3, 3'd5, 3'd7, 3'd1};
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (a_in_ready !== 1'b1) begin tests_failed++; $display("FAIL defaults_in_ready[%0d] got %b, required 1", i, a_in_ready); end
            tests_run++;
            if (a_out_valid !== 1'b0) begin tests_failed++; $display("FAIL defaults_early_valid[%0d] got %b, required 0", i, a_out_valid); end
            a_in_valid = 1'b1;
            a_in_data  = vals[i];
            tick();
        end
        a_in_valid = 1'b0;
        a_q.push_back({1'b0, 8'd16});
        tests_run++;
        if (a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL defaults_out_valid got %b, required 1", a_out_valid); end
        tests_run++;
        if (a_cnt !== 2'd0) begin tests_failed++; $display("FAIL defaults_sample_cnt got %0d, required 0", a_cnt); end
        tests_run++;
        if (a_in_ready !== 1'b0) begin tests_failed++; $display("FAIL defaults_hold_in_ready got %b, required 0", a_in_ready); end
        drain_a();
        tests_run++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL defaults_after_accept got valid=%b ready=%b, required valid=0 ready=1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) send_a(3'd2);
        a_in_valid  = 1'b1;
        a_in_data   = 3'd7;
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_out_sum !== 8'd8 || a_cnt !== 2'd0) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d] got valid=%b ready=%b sum=%0d cnt=%0d, required valid=1 ready=0 sum=8 cnt=0",
                         i, a_out_valid, a_in_ready, a_out_sum, a_cnt);
            end
        end
        a_q.push_back({1'b0, 8'd8});
        drain_a();
        a_in_valid = 1'b0;
        tests_run++;
        if (a_out_valid !== 1'b0 || a_cnt !== 2'd0) begin
            tests_failed++;
            $display("FAIL backpressure_release got valid=%b cnt=%0d, required valid=0 cnt=0", a_out_valid, a_cnt);
        end
        send_a(3'd1);
        send_a(3'd2);
        send_a(3'd3);
        send_a(3'd4);
        a_q.push_back({1'b0, 8'd10});
        tests_run++;
        if (a_out_valid !== 1'b1) begin tests_failed++; $display("FAIL backpressure_next_valid got %b, required 1", a_out_valid); end
        drain_a();
    endtask

    task automatic test_overflow();
        send_b(3'd7);
        send_b(3'd7);
        send_b(3'd7);
        send_b(3'd0);
        b_q.push_back({1'b1, 4'd5});
        tests_run++;
        if (b_out_valid !== 1'b1) begin tests_failed++; $display("FAIL overflow_valid got %b, required 1", b_out_valid); end
        drain_b();
        for (int i = 0; i < 4; i++) send_b(3'd1);
        b_q.push_back({1'b0, 4'd4});
        tests_run++;
        if (b_out_overflow !== 1'b0) begin tests_failed++; $display("FAIL overflow_cleared got %b, required 0", b_out_overflow); end
        drain_b();
    endtask

    task automatic test_bubbles();
        logic [3:0] vld;
        logic [2:0] dat[7];
        logic [1:0] cnt_exp[7];
        logic [6:0] v;
        v       = 7'b1101001;
        dat     = '{3'd6, 3'd0, 3'd0, 3'd1, 3'd0, 3'd4, 3'd2};
        cnt_exp = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
        vld     = 4'd0;
        for (int i = 0; i < 7; i++) begin
            a_in_valid = v[i];
            a_in_data  = dat[i];
            tick();
            tests_run++;
            if (a_cnt !== cnt_exp[i]) begin
                tests_failed++;
                $display("FAIL bubbles_sample_cnt[%0d] got %0d, required %0d", i, a_cnt, cnt_exp[i]);
            end
            vld = vld + {3'd0, v[i]};
        end
        a_in_valid = 1'b0;
        a_q.push_back({1'b0, 8'd13});
        tests_run++;
        if (a_out_valid !== 1'b1 || vld !== 4'd4) begin
            tests_failed++;
            $display("FAIL bubbles_out_valid got %b, required 1", a_out_valid);
        end
        drain_a();
    endtask

    task automatic test_clear();
        send_a(3'd7);
        send_a(3'd7);
        tests_run++;
        if (a_cnt !== 2'd2) begin tests_failed++; $display("FAIL clear_pre_cnt got %0d, required 2", a_cnt); end
        clear      = 1'b1;
        a_in_valid = 1'b1;
        a_in_data  = 3'd5;
        tick();
        clear      = 1'b0;
        a_in_valid = 1'b0;
        tests_run++;
        if (a_cnt !== 2'd0 || a_out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_state got cnt=%0d valid=%b, required cnt=0 valid=0", a_cnt, a_out_valid);
        end
        for (int i = 0; i < 4; i++) send_a(3'd1);
        a_q.push_back({1'b0, 8'd4});
        drain_a();
    endtask

    task automatic test_rst_hold();
        for (int i = 0; i < 4; i++) send_a(3'd3);
        tests_run++;
        if (a_out_valid !== 1'b1 || a_out_sum !== 8'd12) begin
            tests_failed++;
            $display("FAIL rst_hold_pre got valid=%b sum=%0d, required valid=1 sum=12", a_out_valid, a_out_sum);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (a_out_valid !== 1'b0 || a_out_sum !== 8'd0 || a_out_overflow !== 1'b0 || a_in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_hold_post got valid=%b sum=%0d ovf=%b ready=%b, required valid=0 sum=0 ovf=0 ready=1",
                     a_out_valid, a_out_sum, a_out_overflow, a_in_ready);
        end
        for (int i = 0; i < 4; i++) send_a(3'd2);
        a_q.push_back({1'b0, 8'd8});
        drain_a();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        clear        = 1'b0;
        a_in_valid   = 1'b0;
        a_in_data    = 3'd0;
        a_out_ready  = 1'b0;
        b_in_valid   = 1'b0;
        b_in_data    = 3'd0;
        b_out_ready  = 1'b0;

        test_reset();
        test_defaults();
        test_backpressure();
        test_overflow();
        test_bubbles();
        test_clear();
        test_rst_hold();

        tick();
        tests_run++;
        if (a_q.size() != 0 || b_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_leftover got a=%0d b=%0d, required 0 0", a_q.size(), b_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
